mux8_sel_reg: RTL and testbench
===============================

Name: mux8_sel_reg

Overview:
- 8-to-1 selector with a registered output.
- Eight data inputs a..h; one of them is chosen by the 3-bit select {x2,x1,x0}.
- The chosen value is registered on the rising clock edge.
- Used as a generic leaf selector in datapaths; WIDTH defaults to 1 bit, matching the original scalar mux usage.

Parameters:
- WIDTH, 1: bit width of each data input and of out.
- RST_VAL, 0: value loaded into out (all WIDTH bits, zero-extended) on reset.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- a  input  WIDTH  data input, select 3'b000
- b  input  WIDTH  data input, select 3'b001
- c  input  WIDTH  data input, select 3'b010
- d  input  WIDTH  data input, select 3'b011
- e  input  WIDTH  data input, select 3'b100
- f  input  WIDTH  data input, select 3'b101
- g  input  WIDTH  data input, select 3'b110
- h  input  WIDTH  data input, select 3'b111
- x0  input  1  select bit 0 (LSB)
- x1  input  1  select bit 1
- x2  input  1  select bit 2 (MSB)
- in_valid  input  1  qualifies a capture; when low, out holds
- out  output  WIDTH  registered selected data
- out_valid  output  1  high for one cycle after each accepted capture

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. No asynchronous paths into state.
- sel = {x2,x1,x0}. Mapping: 0→a, 1→b, 2→c, 3→d, 4→e, 5→f, 6→g, 7→h. The mapping is total; there are no illegal codes.
- Rising edge with rst=1: out←RST_VAL, out_valid←0. Reset has priority over in_valid.
- Rising edge with rst=0 and in_valid=1: out←selected input sampled at that edge; out_valid←1.
- Rising edge with rst=0 and in_valid=0: out holds its value; out_valid←0.
- Latency: exactly 1 cycle from data/select/in_valid sampled to out/out_valid.
- Select or data changing every cycle: each edge captures independently. There is no glitch memory and no dependency on the previous select.
- Reset asserted mid-stream: the capture in that cycle is discarded and out goes to RST_VAL on the same edge. The first capture after rst deasserts follows the normal rule.
- X/Z on a select bit is not defined behaviour. Verification drives only known values.
- Outputs are driven directly from flops; there is no combinational input-to-output path by default.

Optional Feature:
- Macro: MUX8_SEL_REG_COMB_OUT_EN.
- Defined: adds output port out_comb (output, WIDTH), the purely combinational selection of a..h by {x2,x1,x0}. It has zero latency and ignores in_valid and rst. The registered out and out_valid are unchanged.
- Not defined: the out_comb port does not exist.

Decomposition:
- Package mux8_sel_pkg holds:
  - SEL_W = 3
  - NUM_IN = 8
  - typedef sel_t (logic [SEL_W-1:0])
  - named constants SEL_A = 3'd0 through SEL_H = 3'd7
- Sub-module mux8_sel_comb: combinational WIDTH-parameterised 8:1 select (case on sel_t).
  - Instantiated once inside mux8_sel_reg.
  - Its output feeds the capture flops and, when the macro is defined, out_comb.

Test Plan:
- Reset: rst=1 for 2 cycles with a..h=1, in_valid=1 -> out=0, out_valid=0. Release rst, sel=0, a=1, in_valid=1 -> out=1 and out_valid=1 one cycle later.
- Exhaustive walk (WIDTH=1): a=1, all others 0, sweep sel 0..7 with in_valid=1 -> out=1 only for sel=0. Repeat with the single 1 moved to each input; out=1 only when sel matches that input's code.
- Hold: capture sel=5 with f=1, then drop in_valid and change f=0 and sel=2 -> out stays 1 and out_valid=0 while in_valid stays low.
- Back-to-back: WIDTH=8, a..h=8'h10..8'h17, sel incrementing each cycle 0..7 -> out = 8'h10..8'h17 each delayed one cycle, out_valid continuously 1.
- Mid-stream reset: sel=7, h=8'hAA, in_valid=1 and rst=1 on the same edge -> out=RST_VAL (0), out_valid=0.
- With MUX8_SEL_REG_COMB_OUT_EN: sel=3, d=8'h5C -> out_comb=8'h5C in the same cycle, including while rst=1.

Source files
------------

// File: rtl/mux8_sel_pkg.sv
// mux8_sel_pkg: shared select width, select type and input codes
// for the registered 8:1 selector.
package mux8_sel_pkg;

    localparam int SEL_W  = 3;
    localparam int NUM_IN = 8;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_A = 3'd0;
    localparam sel_t SEL_B = 3'd1;
    localparam sel_t SEL_C = 3'd2;
    localparam sel_t SEL_D = 3'd3;
    localparam sel_t SEL_E = 3'd4;
    localparam sel_t SEL_F = 3'd5;
    localparam sel_t SEL_G = 3'd6;
    localparam sel_t SEL_H = 3'd7;

endpackage

// File: rtl/mux8_sel_comb.sv
// mux8_sel_comb: combinational WIDTH-bit 8:1 select.
// Every select code maps to one input, so there is no illegal code.
module mux8_sel_comb
    import mux8_sel_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  sel_t             sel,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a;
        unique case (sel)
            SEL_A: y = a;
            SEL_B: y = b;
            SEL_C: y = c;
            SEL_D: y = d;
            SEL_E: y = e;
            SEL_F: y = f;
            SEL_G: y = g;
            SEL_H: y = h;
        endcase
    end

endmodule

// File: rtl/mux8_sel_reg.sv
// mux8_sel_reg: 8:1 selector with registered out/out_valid.
// MUX8_SEL_REG_COMB_OUT_EN adds the unregistered out_comb port.
module mux8_sel_reg
    import mux8_sel_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  logic             x0,
    input  logic             x1,
    input  logic             x2,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
`ifdef MUX8_SEL_REG_COMB_OUT_EN
    output logic [WIDTH-1:0] out_comb,
`endif
    output logic             out_valid
);

    sel_t             sel;
    logic [WIDTH-1:0] sel_data;

    assign sel = {x2, x1, x0};

    mux8_sel_comb #(
        .WIDTH (WIDTH)
    ) u_sel (
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .e   (e),
        .f   (f),
        .g   (g),
        .h   (h),
        .sel (sel),
        .y   (sel_data)
    );

    // Reset wins over a capture on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= RST_VAL;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= sel_data;
            end
        end
    end

`ifdef MUX8_SEL_REG_COMB_OUT_EN
    assign out_comb = sel_data;
`endif

endmodule

// File: tb/tb_mux8_sel_reg.sv
// tb_mux8_sel_reg: scoreboard bench for the registered 8:1 selector.
// Expected results are queued at drive time and checked after the edge.
module tb_mux8_sel_reg;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] o;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din [8];
    logic [2:0]   sel;
    logic         in_valid;
    logic [W-1:0] out;
    logic         out_valid;
`ifdef MUX8_SEL_REG_COMB_OUT_EN
    logic [W-1:0] out_comb;
`endif

    int checks   = 0;
    int failures = 0;

    exp_t         q [$];
    logic [W-1:0] m_out;

    always #5 clk = ~clk;

    mux8_sel_reg #(
        .WIDTH   (W),
        .RST_VAL ('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (din[0]),
        .b         (din[1]),
        .c         (din[2]),
        .d         (din[3]),
        .e         (din[4]),
        .f         (din[5]),
        .g         (din[6]),
        .h         (din[7]),
        .x0        (sel[0]),
        .x1        (sel[1]),
        .x2        (sel[2]),
        .in_valid  (in_valid),
        .out       (out),
`ifdef MUX8_SEL_REG_COMB_OUT_EN
        .out_comb  (out_comb),
`endif
        .out_valid (out_valid)
    );

    task automatic chk(
        input string        tag,
        input logic [W-1:0] got,
        input logic [W-1:0] exp
    );
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h",
                     tag, got, exp);
        end
    endtask

    // Model the edge, queue the result, then check it after the edge.
    task automatic step(input string tag);
        exp_t x;
        if (rst) begin
            m_out = '0;
        end else if (in_valid) begin
            m_out = din[sel];
        end
        x.o = m_out;
        x.v = !rst && in_valid;
        q.push_back(x);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk({tag, "_q"}, 8'd0, 8'd1);
        end else begin
            x = q.pop_front();
            chk({tag, "_out"}, out, x.o);
            chk({tag, "_vld"}, {7'd0, out_valid}, {7'd0, x.v});
        end
    endtask

    task automatic set_all(input logic [W-1:0] v);
        for (int i = 0; i < 8; i++) din[i] = v;
    endtask

    initial begin
        m_out    = '0;
        rst      = 1'b1;
        in_valid = 1'b1;
        sel      = 3'd0;
        set_all(8'd1);

        step("rst0");
        step("rst1");

        rst = 1'b0;
        set_all(8'd0);
        din[0] = 8'd1;
        step("rel");

        for (int k = 0; k < 8; k++) begin
            set_all(8'd0);
            din[k] = 8'd1;
            for (int s = 0; s < 8; s++) begin
                sel = 3'(s);
                step($sformatf("walk%0d_%0d", k, s));
            end
        end

        set_all(8'd0);
        din[5] = 8'd1;
        sel    = 3'd5;
        step("hold_cap");
        in_valid = 1'b0;
        din[5]   = 8'd0;
        sel      = 3'd2;
        din[2]   = 8'h3C;
        step("hold0");
        step("hold1");
        step("hold2");

        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) din[i] = 8'h10 + 8'(i);
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            step($sformatf("b2b%0d", s));
        end

        din[7] = 8'hAA;
        sel    = 3'd7;
        step("pre_mid");
        rst = 1'b1;
        step("mid_rst");
        rst = 1'b0;
        step("post_rst");

`ifdef MUX8_SEL_REG_COMB_OUT_EN
        din[3] = 8'h5C;
        sel    = 3'd3;
        rst    = 1'b1;
        #1;
        chk("comb_rst", out_comb, 8'h5C);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("comb", out_comb, 8'h5C);
        sel = 3'd7;
        #1;
        chk("comb_h", out_comb, 8'hAA);
`endif

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
